steer_encoder: RTL and testbench
================================

# steer_encoder

APB-slave quadrature-encoder front end for the steering servo loop. It filters and decodes the A/B/index signals from the steering-shaft encoder into a saturating 10-bit absolute position, plus a per-sample-window velocity. It raises a one-cycle sample interrupt so software can read the position and forward it to the steering controller as the actual-position word.

## Interface
Parameters:
- SAMPLE_DIV, 100000: PCLK cycles per sample window (1 kHz at 100 MHz).
- POS_MAX, 1023: upper position limit; lower limit is 0.
- HOME_VAL, 512: position loaded on an armed index pulse (steering center).
- FILT_RST, 4: reset value of the filter length register.

Ports:
- PCLK  in  1  sole clock.
- PRESETN  in  1  reset, synchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  8  APB address; bits [3:2] decoded.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  constant 0.
- ENC_A, ENC_B, ENC_I  in  1 each  asynchronous encoder phases and index.
- POSINT  out  1  one-cycle pulse at the end of each sample window.

## Operation
- Registers:
  - 0x00 POS (RO): [9:0] position, [16] homed, [17] err (sticky).
  - 0x04 CTRL (RW): [0] enable, [1] home_arm, [2] err_clr (self-clearing, reads 0), [3] dir_inv.
  - 0x08 VEL (RO): [10:0] signed velocity, sign-extended to 32 bits.
  - 0x0C FILT (RW): [7:0] filter length N.
  - Unmapped reads return 0.
- APB protocol:
  - Write commits on the cycle where PSEL & PENABLE & PWRITE.
  - PRDATA is driven combinationally whenever PSEL & !PWRITE; it is 0 otherwise.
- Input path:
  - Each input goes through a 2-flop synchronizer.
  - A per-input glitch filter follows: the filtered output takes the synchronized value only after that value has differed from the current output for N+1 consecutive cycles.
  - N=0 gives a 1-cycle qualification.
- Decode, on filtered {A,B}, previous vs current each cycle:
  - Sequence 00→01→11→10→00 counts +1; the reverse sequence counts −1.
  - No change: no count.
  - Both bits changing at once: no count, err←1.
  - dir_inv=1 swaps the sign of every count.
- Position:
  - 10-bit unsigned, saturating: +1 at POS_MAX and −1 at 0 are discarded.
  - The counter updates only when enable=1.
  - The previous-AB state is always tracked, so re-enabling never produces a spurious count.
- Homing:
  - On a filtered ENC_I rising edge while home_arm=1: position←HOME_VAL, homed←1, home_arm←0.
  - If an index load and a count occur in the same cycle, the index load wins.
  - An index edge with home_arm=0 is ignored.
  - Homing works regardless of enable.
- err_clr:
  - Clears err, except when a new illegal transition occurs in the same cycle, in which case err stays 1.
- Sample window:
  - A free-running counter counts 0..SAMPLE_DIV−1.
  - On the terminal count: VEL←signed(pos − pos_snap), pos_snap←pos, POSINT=1 for that one cycle.
  - Velocity arithmetic is 11-bit signed, so it cannot overflow for a 10-bit position.
  - A homing load inside the window shows up as a velocity jump; this is accepted.

## Timing
- Reset values (PRESETN=0 at a PCLK edge):
  - position=HOME_VAL, homed=0, err=0, enable=0, home_arm=0, dir_inv=0.
  - N=FILT_RST, VEL=0, pos_snap=HOME_VAL, sample counter=0.
  - POSINT=0, filter outputs and previous-AB = 0.
- Reset applied mid-window or mid-filter discards all in-progress state.
- Latency from a pin edge to the position update is 2 (synchronizer) + N+1 (filter) + 1 (count register) PCLK cycles. With N=4 that is 8 cycles.
- CTRL written in cycle T takes effect on counting from cycle T+1.
- A POS read returns the registered value as of the start of the access phase.
- POSINT has period SAMPLE_DIV cycles. The first pulse occurs SAMPLE_DIV cycles after reset is released.
- Maximum countable edge rate is one legal transition per N+2 cycles per phase; faster input is filtered out or flagged as err.

## Test plan
- Reset, then read all registers → POS=0x200, CTRL=0, VEL=0, FILT=4; POSINT stays low for 99999 cycles, then pulses for exactly 1 cycle.
- Enable, apply 10 forward quadrature steps (each phase held 20 cycles) → POS=522; at the next POSINT, VEL=+10. Repeat in reverse with dir_inv=1 → POS=532.
- Write FILT=4, inject 4-cycle glitches on A → no count and err=0. Then toggle A and B in the same cycle → err=1, no count. Write err_clr → err=0.
- Drive the position to 1023 and apply 5 more forward steps → POS stays 1023. Drive to 0 and apply 3 reverse steps → stays 0. Next VEL matches the clamped delta.
- Arm homing from POS=100 and pulse ENC_I with a simultaneous forward step → POS=512, homed=1, home_arm reads 0. A second index pulse leaves POS unchanged.
- Hold PRESETN low for 1 cycle mid-window after counting to 700 → all registers return to reset values and the next POSINT arrives SAMPLE_DIV cycles after release.

Source files
------------

// File: rtl/steer_encoder.sv
// ---------------------------------------------------------------------------
// steer_encoder
// Quadrature-encoder front end for the steering servo loop, with an APB slave.
// A/B/index go through 2-flop synchronizers and per-input glitch filters. The
// filtered A/B pair is decoded into a saturating 10-bit absolute position.
// A sample window produces a signed velocity and a one-cycle POSINT pulse.
//
// Ports:
//   PCLK                 sole clock
//   PRESETN              synchronous active-low reset
//   PSEL/PENABLE/PWRITE  APB control
//   PADDR[7:0]           APB address, bits [3:2] decoded
//   PWDATA[31:0]         APB write data
//   PRDATA[31:0]         APB read data (combinational, 0 when not reading)
//   PREADY / PSLVERR     tied 1 / 0
//   ENC_A/ENC_B/ENC_I    asynchronous encoder phases and index
//   POSINT               one-cycle pulse at the end of each sample window
//
// Register map:
//   0x00 POS  (RO) [9:0] position, [16] homed, [17] err (sticky)
//   0x04 CTRL (RW) [0] enable, [1] home_arm, [2] err_clr (write-only), [3] dir_inv
//   0x08 VEL  (RO) [10:0] signed velocity, sign-extended
//   0x0C FILT (RW) [7:0] filter length N
// ---------------------------------------------------------------------------
module steer_encoder #(
   parameter int SAMPLE_DIV = 100000,
   parameter int POS_MAX    = 1023,
   parameter int HOME_VAL   = 512,
   parameter int FILT_RST   = 4
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic        ENC_A,
   input  logic        ENC_B,
   input  logic        ENC_I,
   output logic        POSINT
);

   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] WIN_LAST = CW'(SAMPLE_DIV - 1);
   localparam logic [9:0]    POS_TOP  = 10'(POS_MAX);
   localparam logic [9:0]    HOME_POS = 10'(HOME_VAL);
   localparam logic [7:0]    FILT_DEF = 8'(FILT_RST);

   // Input bit order throughout the input path: [2]=A, [1]=B, [0]=index.
   logic [2:0]  sync1_r, sync2_r, filt_r;
   logic [7:0]  fcnt_r [3];
   logic [1:0]  prev_ab_r;
   logic        prev_i_r;

   logic [9:0]  pos_r, snap_r;
   logic        homed_r, err_r;
   logic        enable_r, home_arm_r, dir_inv_r;
   logic [7:0]  filt_n_r;
   logic [10:0] vel_r;
   logic [CW-1:0] scnt_r;
   logic        posint_r;

   logic [1:0]  cur_ab_s;
   logic        step_up_s, step_dn_s, illegal_s;
   logic        inc_s, dec_s;
   logic        index_load_s;
   logic [9:0]  pos_nxt_s;
   logic        err_nxt_s;
   logic        wr_s, ctrl_wr_s, filt_wr_s, err_clr_s;
   logic        unused_s;

   assign PREADY   = 1'b1;
   assign PSLVERR  = 1'b0;
   assign POSINT   = posint_r;
   assign cur_ab_s = filt_r[2:1];
   assign unused_s = ^{PADDR[7:4], PADDR[1:0], PWDATA[31:8]};

   assign wr_s      = PSEL & PENABLE & PWRITE;
   assign ctrl_wr_s = wr_s & (PADDR[3:2] == 2'b01);
   assign filt_wr_s = wr_s & (PADDR[3:2] == 2'b11);
   assign err_clr_s = ctrl_wr_s & PWDATA[2];

   // Index load only on a filtered rising edge while armed, independent of enable.
   assign index_load_s = filt_r[0] & ~prev_i_r & home_arm_r;

   // Two-flop synchronizer for the asynchronous encoder pins.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
      end else begin
         sync1_r <= {ENC_A, ENC_B, ENC_I};
         sync2_r <= sync1_r;
      end
   end

   // Glitch filter: output follows only after N+1 consecutive differing cycles.
   // The >= compare keeps a stale count safe if N is lowered mid-run.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         filt_r <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            fcnt_r[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] != filt_r[i]) begin
               if (fcnt_r[i] >= filt_n_r) begin
                  filt_r[i] <= sync2_r[i];
                  fcnt_r[i] <= 8'd0;
               end else begin
                  fcnt_r[i] <= fcnt_r[i] + 8'd1;
               end
            end else begin
               fcnt_r[i] <= 8'd0;
            end
         end
      end
   end

   // Quadrature decode of previous vs current filtered {A,B}.
   always_comb begin
      step_up_s = 1'b0;
      step_dn_s = 1'b0;
      illegal_s = 1'b0;
      case ({prev_ab_r, cur_ab_s})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: step_up_s = 1'b1;
         4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dn_s = 1'b1;
         4'b0011, 4'b0110, 4'b1001, 4'b1100: illegal_s = 1'b1;
         default: begin
            step_up_s = 1'b0;
            step_dn_s = 1'b0;
            illegal_s = 1'b0;
         end
      endcase
   end

   // Direction inversion swaps the meaning of the two decoded steps.
   always_comb begin
      inc_s = 1'b0;
      dec_s = 1'b0;
      if (dir_inv_r) begin
         inc_s = step_dn_s;
         dec_s = step_up_s;
      end else begin
         inc_s = step_up_s;
         dec_s = step_dn_s;
      end
   end

   // Next position: index load beats counting; counting saturates at both ends.
   always_comb begin
      pos_nxt_s = pos_r;
      if (index_load_s) begin
         pos_nxt_s = HOME_POS;
      end else if (enable_r && inc_s && (pos_r != POS_TOP)) begin
         pos_nxt_s = pos_r + 10'd1;
      end else if (enable_r && dec_s && (pos_r != 10'd0)) begin
         pos_nxt_s = pos_r - 10'd1;
      end else begin
         pos_nxt_s = pos_r;
      end
   end

   // Sticky error: a new illegal transition wins over a same-cycle clear.
   always_comb begin
      err_nxt_s = err_r;
      if (illegal_s) begin
         err_nxt_s = 1'b1;
      end else if (err_clr_s) begin
         err_nxt_s = 1'b0;
      end else begin
         err_nxt_s = err_r;
      end
   end

   // Position, homing status, error and edge-history registers.
   // Edge history is tracked even while disabled so re-enabling never counts.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         pos_r     <= HOME_POS;
         homed_r   <= 1'b0;
         err_r     <= 1'b0;
         prev_ab_r <= 2'b00;
         prev_i_r  <= 1'b0;
      end else begin
         pos_r     <= pos_nxt_s;
         err_r     <= err_nxt_s;
         prev_ab_r <= cur_ab_s;
         prev_i_r  <= filt_r[0];
         if (index_load_s) begin
            homed_r <= 1'b1;
         end
      end
   end

   // Software control registers; an index load disarms homing unless
   // software rewrites CTRL in that same cycle.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         enable_r   <= 1'b0;
         home_arm_r <= 1'b0;
         dir_inv_r  <= 1'b0;
         filt_n_r   <= FILT_DEF;
      end else begin
         if (ctrl_wr_s) begin
            enable_r   <= PWDATA[0];
            home_arm_r <= PWDATA[1];
            dir_inv_r  <= PWDATA[3];
         end else if (index_load_s) begin
            home_arm_r <= 1'b0;
         end
         if (filt_wr_s) begin
            filt_n_r <= PWDATA[7:0];
         end
      end
   end

   // Sample window: velocity snapshot and POSINT pulse on the terminal count.
   // 11-bit difference of two zero-extended 10-bit values cannot overflow.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         scnt_r   <= {CW{1'b0}};
         vel_r    <= 11'd0;
         snap_r   <= HOME_POS;
         posint_r <= 1'b0;
      end else if (scnt_r == WIN_LAST) begin
         scnt_r   <= {CW{1'b0}};
         vel_r    <= {1'b0, pos_r} - {1'b0, snap_r};
         snap_r   <= pos_r;
         posint_r <= 1'b1;
      end else begin
         scnt_r   <= scnt_r + CW'(1);
         posint_r <= 1'b0;
      end
   end

   // APB read mux, driven whenever a read is selected.
   always_comb begin
      PRDATA = 32'd0;
      if (PSEL && !PWRITE) begin
         case (PADDR[3:2])
            2'b00:   PRDATA = {14'd0, err_r, homed_r, 6'd0, pos_r};
            2'b01:   PRDATA = {28'd0, dir_inv_r, 1'b0, home_arm_r, enable_r};
            2'b10:   PRDATA = {{21{vel_r[10]}}, vel_r};
            2'b11:   PRDATA = {24'd0, filt_n_r};
            default: PRDATA = 32'd0;
         endcase
      end else begin
         PRDATA = 32'd0;
      end
   end

endmodule

// File: tb/tb_steer_encoder.sv
// ---------------------------------------------------------------------------
// tb_steer_encoder
// Directed bench for steer_encoder with a shortened sample window. Expected
// values are hand-computed constants; all comparisons go through check_eq.
// ---------------------------------------------------------------------------
module tb_steer_encoder;

   localparam int SD = 1000;

   logic        PCLK = 1'b0;
   logic        PRESETN = 1'b0;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [7:0]  PADDR = 8'h00;
   logic [31:0] PWDATA = 32'h0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        ENC_A = 1'b0;
   logic        ENC_B = 1'b0;
   logic        ENC_I = 1'b0;
   logic        POSINT;

   int checks = 0;
   int errors = 0;
   int tick = 0;
   int pulse_cnt = 0;
   int first_pulse = 0;
   logic [1:0]  ab_s = 2'b00;
   logic [31:0] rd_s;

   steer_encoder #(.SAMPLE_DIV(SD)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .ENC_A(ENC_A), .ENC_B(ENC_B),
      .ENC_I(ENC_I), .POSINT(POSINT)
   );

   always #5 PCLK = ~PCLK;

   // Edges since the last reset edge (0 at the reset edge itself).
   always @(posedge PCLK) begin
      if (!PRESETN) tick <= 0;
      else          tick <= tick + 1;
   end

   // Records when POSINT is first seen high and how many cycles it is high.
   always @(negedge PCLK) begin
      if (!PRESETN) begin
         pulse_cnt   = 0;
         first_pulse = 0;
      end else if (POSINT) begin
         pulse_cnt = pulse_cnt + 1;
         if (first_pulse == 0) first_pulse = tick;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      data = PRDATA;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      apb_read(addr, d);
      check_eq(tag, d, exp);
   endtask

   // One quadrature step; fwd follows 00->01->11->10->00.
   task automatic step(input bit fwd, input int hold);
      if (fwd) begin
         case (ab_s)
            2'b00: ab_s = 2'b01;
            2'b01: ab_s = 2'b11;
            2'b11: ab_s = 2'b10;
            default: ab_s = 2'b00;
         endcase
      end else begin
         case (ab_s)
            2'b00: ab_s = 2'b10;
            2'b10: ab_s = 2'b11;
            2'b11: ab_s = 2'b01;
            default: ab_s = 2'b00;
         endcase
      end
      ENC_A = ab_s[1];
      ENC_B = ab_s[0];
      repeat (hold) @(posedge PCLK);
      #1;
   endtask

   task automatic steps(input bit fwd, input int n, input int hold);
      for (int k = 0; k < n; k++) step(fwd, hold);
   endtask

   task automatic wait_posint(input string tag);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < SD + 20) begin
         @(negedge PCLK);
         if (POSINT) seen = 1'b1;
         n = n + 1;
      end
      check_eq(tag, {31'd0, seen}, 32'd1);
      @(posedge PCLK); #1;
   endtask

   task automatic check_reset_regs(input string tag);
      read_check({tag, "_pos"},  8'h00, 32'h0000_0200);
      read_check({tag, "_ctrl"}, 8'h04, 32'h0000_0000);
      read_check({tag, "_vel"},  8'h08, 32'h0000_0000);
      read_check({tag, "_filt"}, 8'h0C, 32'h0000_0004);
   endtask

   task automatic check_first_window(input string tag);
      while (tick < SD + 2) begin
         @(posedge PCLK); #1;
      end
      check_eq({tag, "_first_pulse_at"}, first_pulse, SD);
      check_eq({tag, "_pulse_width"}, pulse_cnt, 1);
   endtask

   initial begin
      repeat (3) @(posedge PCLK);
      #1;
      PRESETN = 1'b1;

      // Reset state
      check_reset_regs("rst");
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h00;
      @(negedge PCLK);
      check_eq("prdata_on_write", PRDATA, 32'h0);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PWRITE = 1'b0;
      check_first_window("rst");

      // Forward counting and velocity
      apb_write(8'h04, 32'h1);
      steps(1'b1, 10, 20);
      read_check("fwd_pos", 8'h00, 32'd522);
      wait_posint("fwd_posint");
      read_check("fwd_vel", 8'h08, 32'd10);

      // Reverse motion with inverted direction counts up
      apb_write(8'h04, 32'h9);
      steps(1'b0, 10, 20);
      read_check("inv_pos", 8'h00, 32'd532);
      wait_posint("inv_posint");
      read_check("inv_vel", 8'h08, 32'd10);

      // Glitch rejection, illegal transition and error clear
      apb_write(8'h0C, 32'h4);
      read_check("filt_rb", 8'h0C, 32'h4);
      apb_write(8'h04, 32'h1);
      for (int g = 0; g < 3; g++) begin
         ENC_A = ~ENC_A;
         repeat (4) @(posedge PCLK);
         #1;
         ENC_A = ~ENC_A;
         repeat (20) @(posedge PCLK);
         #1;
      end
      read_check("glitch_pos", 8'h00, 32'd532);
      ab_s = ~ab_s;
      ENC_A = ab_s[1];
      ENC_B = ab_s[0];
      repeat (20) @(posedge PCLK);
      #1;
      read_check("illegal_pos", 8'h00, 32'h0002_0214);
      apb_write(8'h04, 32'h5);
      read_check("errclr_pos", 8'h00, 32'h0000_0214);
      read_check("errclr_ctrl", 8'h04, 32'h1);

      // Upper saturation
      steps(1'b1, 489, 10);
      wait_posint("sat_hi_posint0");
      steps(1'b1, 5, 10);
      read_check("sat_hi_pos", 8'h00, 32'd1023);
      wait_posint("sat_hi_posint1");
      read_check("sat_hi_vel", 8'h08, 32'd2);

      // Lower saturation
      steps(1'b0, 1021, 10);
      wait_posint("sat_lo_posint0");
      steps(1'b0, 5, 10);
      read_check("sat_lo_pos", 8'h00, 32'd0);
      wait_posint("sat_lo_posint1");
      read_check("sat_lo_vel", 8'h08, 32'hFFFF_FFFE);

      // Homing with a simultaneous forward step
      steps(1'b1, 100, 10);
      read_check("pre_home_pos", 8'h00, 32'd100);
      apb_write(8'h04, 32'h3);
      read_check("armed_ctrl", 8'h04, 32'h3);
      ENC_I = 1'b1;
      step(1'b1, 20);
      ENC_I = 1'b0;
      repeat (20) @(posedge PCLK);
      #1;
      read_check("home_pos", 8'h00, 32'h0001_0200);
      read_check("home_ctrl", 8'h04, 32'h1);
      step(1'b1, 20);
      ENC_I = 1'b1;
      repeat (20) @(posedge PCLK);
      #1;
      ENC_I = 1'b0;
      repeat (20) @(posedge PCLK);
      #1;
      read_check("unarmed_index_pos", 8'h00, 32'h0001_0201);

      // Count to 700, park pins at 00 while disabled, reset mid-window
      steps(1'b1, 187, 10);
      read_check("pos_700", 8'h00, 32'h0001_02BC);
      apb_write(8'h04, 32'h8);
      while (ab_s != 2'b00) step(1'b1, 10);
      read_check("disabled_pos", 8'h00, 32'h0001_02BC);
      apb_write(8'h0C, 32'h7);
      wait_posint("pre_reset_posint");
      repeat (300) @(posedge PCLK);
      #1;
      PRESETN = 1'b0;
      @(posedge PCLK); #1;
      PRESETN = 1'b1;
      check_reset_regs("midrst");
      check_first_window("midrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
